// File: rtl/mux_test_sequencer_if.sv
// Signal bundle between the mux test sequencer and the two muxes under test.
// The master modport is the sequencer's view; the slave modport is the environment's.
interface mux_test_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             gf_out;
    logic             bfg_out;
    logic             i0;
    logic             i1;
    logic             i2;
    logic             i3;
    logic             s0;
    logic             s1;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] gf_err;
    logic [CNT_W-1:0] bfg_err;
    logic [5:0]       fail_vec;
    logic             fail_valid;
    logic [1:0]       state;

    modport master (
        input  start, abort, gf_out, bfg_out,
        output i0, i1, i2, i3, s0, s1,
        output busy, done, pass, gf_err, bfg_err, fail_vec, fail_valid, state
    );

    modport slave (
        output start, abort, gf_out, bfg_out,
        input  i0, i1, i2, i3, s0, s1,
        input  busy, done, pass, gf_err, bfg_err, fail_vec, fail_valid, state
    );
endinterface

// File: rtl/mux_test_sequencer.sv
// Walks all 64 data/select combinations through two 4:1 muxes, holds each for
// SETTLE cycles, then compares both outputs with the ideal result and counts misses.
module mux_test_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_i,
    mux_test_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [7:0]       RELOAD  = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [5:0]       vec;
    logic [7:0]       wait_cnt;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] gf_err;
    logic [CNT_W-1:0] bfg_err;
    logic [5:0]       fail_vec;
    logic             fail_valid;

    logic             exp_bit;
    logic             gf_miss;
    logic             bfg_miss;

    always_comb begin
        exp_bit  = vec[{vec[5], vec[4]}];
        gf_miss  = (bus.gf_out != exp_bit);
        bfg_miss = (bus.bfg_out != exp_bit);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            vec        <= 6'd0;
            wait_cnt   <= 8'd0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            gf_err     <= '0;
            bfg_err    <= '0;
            fail_vec   <= 6'd0;
            fail_valid <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        vec        <= 6'd0;
                        gf_err     <= '0;
                        bfg_err    <= '0;
                        fail_vec   <= 6'd0;
                        fail_valid <= 1'b0;
                        pass_q     <= 1'b0;
                        wait_cnt   <= RELOAD;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                        state  <= IDLE;
                    end else if (wait_cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    // The sample is scored even when this is also the abort cycle.
                    if (gf_miss && gf_err != CNT_MAX) gf_err <= gf_err + 1'b1;
                    if (bfg_miss && bfg_err != CNT_MAX) bfg_err <= bfg_err + 1'b1;
                    if ((gf_miss || bfg_miss) && !fail_valid) begin
                        fail_vec   <= vec;
                        fail_valid <= 1'b1;
                    end
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                        state  <= IDLE;
                    end else if (vec == 6'd63) begin
                        done_q <= 1'b1;
                        pass_q <= !gf_miss && !bfg_miss && (gf_err == '0) && (bfg_err == '0);
                        state  <= IDLE;
                    end else begin
                        vec      <= vec + 6'd1;
                        wait_cnt <= RELOAD;
                        state    <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i0         = vec[0];
    assign bus.i1         = vec[1];
    assign bus.i2         = vec[2];
    assign bus.i3         = vec[3];
    assign bus.s0         = vec[4];
    assign bus.s1         = vec[5];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.gf_err     = gf_err;
    assign bus.bfg_err    = bfg_err;
    assign bus.fail_vec   = fail_vec;
    assign bus.fail_valid = fail_valid;
    assign bus.state      = state;
endmodule

// File: tb/tb_mux_test_sequencer.sv
// Directed bench: ideal, stuck and inverted mux models, restart, abort and
// mid-run reset, with hand-derived expected counts.
module tb_mux_test_sequencer;
    logic clk;
    logic rst;
    logic bfg_stuck;
    int   checks;
    int   errors;
    int   done_seen;
    int   done_at;
    int   seen_before;
    logic busy1;

    mux_test_sequencer_if #(.CNT_W(8)) bus ();
    mux_test_sequencer_if #(.CNT_W(5)) bus2 ();

    mux_test_sequencer #(.SETTLE(2), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    mux_test_sequencer #(.SETTLE(2), .CNT_W(5)) dut2 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux models: {s1,s0} selects one of i0..i3
    logic [5:0] stim1;
    logic [5:0] stim2;
    assign stim1 = {bus.s1, bus.s0, bus.i3, bus.i2, bus.i1, bus.i0};
    assign stim2 = {bus2.s1, bus2.s0, bus2.i3, bus2.i2, bus2.i1, bus2.i0};

    function automatic logic mux_ref(input logic [5:0] v);
        logic [3:0] d;
        d = v[3:0];
        return d[v[5:4]];
    endfunction

    assign bus.gf_out   = mux_ref(stim1);
    assign bus.bfg_out  = bfg_stuck ? 1'b0 : mux_ref(stim1);
    assign bus2.gf_out  = ~mux_ref(stim2);
    assign bus2.bfg_out = mux_ref(stim2);

    always @(negedge clk) if (bus.done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issues start, then steps cycle by cycle (cycle 0 = the start edge).
    task automatic run_seq(input int abort_at, input int restart_at, input int rst_at,
                           output int d_at, output logic b1);
        d_at = -1;
        b1   = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (n == abort_at)   bus.abort = 1'b1;
            if (n == restart_at) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (n == 1) b1 = bus.busy;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                return;
            end
            if (bus.done) begin
                d_at = n;
                return;
            end
            if (!bus.busy) return;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_seen  = 0;
        bfg_stuck  = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_gf_err", bus.gf_err, 0);
        check("rst_bfg_err", bus.bfg_err, 0);
        check("rst_fail_vec", bus.fail_vec, 0);
        check("rst_fail_valid", bus.fail_valid, 0);
        check("rst_stim", stim1, 0);
        check("rst_state", bus.state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal run on dut; dut2 runs alongside with an inverted gf mux
        run_seq(-1, -1, -1, done_at, busy1);
        check("ideal_busy_after_start", busy1, 1);
        check("ideal_done_cycle", done_at, 192);
        check("ideal_pass", bus.pass, 1);
        check("ideal_gf_err", bus.gf_err, 0);
        check("ideal_bfg_err", bus.bfg_err, 0);
        check("ideal_fail_valid", bus.fail_valid, 0);
        check("ideal_last_vec", stim1, 63);
        check("inv_gf_err_sat", bus2.gf_err, 31);
        check("inv_bfg_err", bus2.bfg_err, 0);
        check("inv_fail_vec", bus2.fail_vec, 0);
        check("inv_fail_valid", bus2.fail_valid, 1);
        check("inv_pass", bus2.pass, 0);
        @(posedge clk);
        #1;
        check("ideal_done_one_cycle", bus.done, 0);
        check("ideal_busy_idle", bus.busy, 0);
        check("ideal_done_count", done_seen, 1);

        // Start repeated mid-run is ignored
        run_seq(-1, 10, -1, done_at, busy1);
        check("restart_done_cycle", done_at, 192);
        check("restart_pass", bus.pass, 1);
        repeat (2) @(negedge clk);

        // bfg stuck at 0: exp is 1 for half the vectors, first at vec 1
        bfg_stuck = 1'b1;
        run_seq(-1, -1, -1, done_at, busy1);
        check("stuck_done_cycle", done_at, 192);
        check("stuck_bfg_err", bus.bfg_err, 32);
        check("stuck_gf_err", bus.gf_err, 0);
        check("stuck_fail_vec", bus.fail_vec, 1);
        check("stuck_fail_valid", bus.fail_valid, 1);
        check("stuck_pass", bus.pass, 0);
        repeat (2) @(negedge clk);

        // Abort on the CHECK edge of vec 15: vecs 0..15 scored, 8 have exp=1
        seen_before = done_seen;
        run_seq(48, -1, -1, done_at, busy1);
        check("abort_no_done", done_at, -1);
        check("abort_busy", bus.busy, 0);
        check("abort_state", bus.state, 0);
        check("abort_bfg_err", bus.bfg_err, 8);
        check("abort_gf_err", bus.gf_err, 0);
        check("abort_fail_vec", bus.fail_vec, 1);
        check("abort_fail_valid", bus.fail_valid, 1);
        check("abort_pass", bus.pass, 0);
        check("abort_vec_held", stim1, 15);
        repeat (250) @(posedge clk);
        #1;
        check("abort_bfg_err_hold", bus.bfg_err, 8);
        check("abort_done_count", done_seen, seen_before);
        bfg_stuck = 1'b0;
        run_seq(-1, -1, -1, done_at, busy1);
        check("rerun_done_cycle", done_at, 192);
        check("rerun_pass", bus.pass, 1);
        check("rerun_bfg_err", bus.bfg_err, 0);
        repeat (2) @(negedge clk);

        // Start and abort together in IDLE: abort wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("start_abort_busy", bus.busy, 0);
        check("start_abort_pass_kept", bus.pass, 1);

        // Reset mid-run with nonzero counters
        bfg_stuck   = 1'b1;
        seen_before = done_seen;
        run_seq(-1, -1, 30, done_at, busy1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_state", bus.state, 0);
        check("mrst_stim", stim1, 0);
        check("mrst_bfg_err", bus.bfg_err, 0);
        check("mrst_fail_valid", bus.fail_valid, 0);
        check("mrst_fail_vec", bus.fail_vec, 0);
        check("mrst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (250) @(negedge clk);
        check("mrst_stays_idle", bus.busy, 0);
        check("mrst_no_done", done_seen, seen_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
